ahb_burst_master: RTL and testbench

Synthesizable, parametrised AHB-Lite master traffic engine. It generalises the single-transfer master stimulus into programmable single or incrementing bursts. Each command sets direction, base address, beat count and data seed. The block sits in front of bridge_top in place of the task-driven master. It checks read data against the seed pattern, counts mismatches, and reports ERROR responses.

---
 rtl/ahb_burst_master.sv | 178 +++++++++++++++++
 tb/tb_ahb_burst_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_master.sv
// AHB-Lite master traffic engine: issues single or incrementing bursts from a
// command, drives a seed+beat data pattern, and checks read data against it.
`timescale 1ns/1ps
module ahb_burst_master #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LEN_W = 5
) (
  input  logic             Hclk,
  input  logic             Hreset,
  input  logic             start,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [DW-1:0]    cmd_seed,
  output logic             busy,
  output logic             done,
  output logic             err_resp,
  output logic [15:0]      mismatch_cnt,
  output logic [1:0]       Htrans,
  output logic [AW-1:0]    Haddr,
  output logic             Hwrite,
  output logic [2:0]       Hsize,
  output logic [DW-1:0]    Hwdata,
  output logic             Hreadyin,
  input  logic             Hreadyout,
  input  logic [1:0]       Hresp,
  input  logic [DW-1:0]    Hrdata
);

  typedef enum logic [2:0] {IDLE, ADDR, PIPE, LASTDATA, ERR, FIN} state_t;

  localparam logic [1:0]    TR_IDLE    = 2'b00;
  localparam logic [1:0]    TR_NONSEQ  = 2'b10;
  localparam logic [1:0]    TR_SEQ     = 2'b11;
  localparam logic [1:0]    RESP_ERROR = 2'b01;
  localparam logic [AW-1:0] ADDR_STEP  = AW'(DW / 8);

  state_t           state, state_n;
  logic [1:0]       htrans_n;
  logic [AW-1:0]    haddr_n;
  logic             hwrite_n;
  logic [DW-1:0]    hwdata_n;
  logic             busy_n, done_n, err_n;
  logic [15:0]      mm_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [DW-1:0]    seed_q, seed_n;
  logic             write_q, write_n;
  logic [LEN_W-1:0] addr_beat, addr_beat_n;
  logic [LEN_W-1:0] data_beat, data_beat_n;

  logic          in_data, data_err, last_addr;
  logic [DW-1:0] exp_rdata;

  assign Hsize    = 3'($clog2(DW / 8));
  assign Hreadyin = 1'b1;

  assign in_data   = (state == PIPE) || (state == LASTDATA);
  assign data_err  = in_data && (Hresp == RESP_ERROR);
  assign last_addr = (addr_beat == len_q - LEN_W'(1));
  assign exp_rdata = seed_q + DW'(data_beat);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_n     = state;
    htrans_n    = Htrans;
    haddr_n     = Haddr;
    hwrite_n    = Hwrite;
    hwdata_n    = Hwdata;
    err_n       = err_resp;
    mm_n        = mismatch_cnt;
    len_n       = len_q;
    seed_n      = seed_q;
    write_n     = write_q;
    addr_beat_n = addr_beat;
    data_beat_n = data_beat;

    // A completed read data phase is checked regardless of what the address side does.
    if (in_data && Hreadyout && !data_err && !write_q &&
        (Hrdata != exp_rdata) && (mismatch_cnt != 16'hFFFF))
      mm_n = mismatch_cnt + 16'd1;

    case (state)
      IDLE: begin
        if (start) begin
          err_n = 1'b0;
          mm_n  = '0;
          if (cmd_len == '0) begin
            state_n = FIN;
          end else begin
            len_n       = cmd_len;
            seed_n      = cmd_seed;
            write_n     = cmd_write;
            addr_beat_n = '0;
            htrans_n    = TR_NONSEQ;
            haddr_n     = cmd_addr;
            hwrite_n    = cmd_write;
            state_n     = ADDR;
          end
        end
      end
      ADDR, PIPE: begin
        if (data_err) begin
          htrans_n = TR_IDLE;
          err_n    = 1'b1;
          state_n  = Hreadyout ? FIN : ERR;
        end else if (Hreadyout) begin
          data_beat_n = addr_beat;
          if (write_q)
            hwdata_n = seed_q + DW'(addr_beat);
          if (last_addr) begin
            htrans_n = TR_IDLE;
            state_n  = LASTDATA;
          end else begin
            addr_beat_n = addr_beat + LEN_W'(1);
            haddr_n     = Haddr + ADDR_STEP;
            htrans_n    = TR_SEQ;
            state_n     = PIPE;
          end
        end
      end
      LASTDATA: begin
        if (data_err) begin
          err_n   = 1'b1;
          state_n = Hreadyout ? FIN : ERR;
        end else if (Hreadyout) begin
          state_n = FIN;
        end
      end
      ERR: begin
        if (Hreadyout)
          state_n = FIN;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == ADDR) || (state_n == PIPE) ||
             (state_n == LASTDATA) || (state_n == ERR);
    done_n = (state_n == FIN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state        <= IDLE;
      Htrans       <= TR_IDLE;
      Haddr        <= '0;
      Hwrite       <= 1'b0;
      Hwdata       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_resp     <= 1'b0;
      mismatch_cnt <= '0;
      len_q        <= '0;
      seed_q       <= '0;
      write_q      <= 1'b0;
      addr_beat    <= '0;
      data_beat    <= '0;
    end else begin
      state        <= state_n;
      Htrans       <= htrans_n;
      Haddr        <= haddr_n;
      Hwrite       <= hwrite_n;
      Hwdata       <= hwdata_n;
      busy         <= busy_n;
      done         <= done_n;
      err_resp     <= err_n;
      mismatch_cnt <= mm_n;
      len_q        <= len_n;
      seed_q       <= seed_n;
      write_q      <= write_n;
      addr_beat    <= addr_beat_n;
      data_beat    <= data_beat_n;
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: per-cycle slave stimulus and expected
// bus outputs are queued, then replayed and compared cycle by cycle.
`timescale 1ns/1ps
module tb_ahb_burst_master;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LEN_W = 5;

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic             Hclk = 1'b0;
  logic             Hreset;
  logic             start;
  logic             cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [DW-1:0]    cmd_seed;
  logic             busy, done, err_resp;
  logic [15:0]      mismatch_cnt;
  logic [1:0]       Htrans;
  logic [AW-1:0]    Haddr;
  logic             Hwrite;
  logic [2:0]       Hsize;
  logic [DW-1:0]    Hwdata;
  logic             Hreadyin;
  logic             Hreadyout;
  logic [1:0]       Hresp;
  logic [DW-1:0]    Hrdata;

  ahb_burst_master #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .start(start), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .busy(busy), .done(done), .err_resp(err_resp), .mismatch_cnt(mismatch_cnt),
    .Htrans(Htrans), .Haddr(Haddr), .Hwrite(Hwrite), .Hsize(Hsize),
    .Hwdata(Hwdata), .Hreadyin(Hreadyin), .Hreadyout(Hreadyout),
    .Hresp(Hresp), .Hrdata(Hrdata)
  );

  always #5 Hclk = ~Hclk;

  // One bus cycle: slave inputs to drive, and the DUT outputs expected in it.
  typedef struct {
    bit          start;
    bit          rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [1:0]  trans;
    logic [31:0] addr;
    bit          wr;
    bit          chk_wd;
    logic [31:0] wd;
    bit          done;
    bit          busy;
  } step_t;

  step_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void push(input bit st, input bit rdy, input logic [1:0] resp,
                               input logic [31:0] rdata, input logic [1:0] trans,
                               input logic [31:0] addr, input bit wr, input bit chk_wd,
                               input logic [31:0] wd, input bit dn, input bit bz);
    step_t s;
    s.start = st;  s.rdy = rdy;   s.resp = resp;     s.rdata = rdata;
    s.trans = trans; s.addr = addr; s.wr = wr;       s.chk_wd = chk_wd;
    s.wd = wd;     s.done = dn;   s.busy = bz;
    sb.push_back(s);
  endfunction

  function automatic void push_idle(input bit st);
    push(st, 1'b1, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic void push_done();
    push(1'b0, 1'b1, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endfunction

  // Replays the queue; called at a falling edge, returns at a falling edge.
  task automatic run(input string name);
    step_t s;
    int    c = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      start     = s.start;
      Hreadyout = s.rdy;
      Hresp     = s.resp;
      Hrdata    = s.rdata;
      check($sformatf("%s.c%0d.Htrans", name, c), 32'(Htrans), 32'(s.trans));
      if (s.trans != 2'b00) begin
        check($sformatf("%s.c%0d.Haddr", name, c), Haddr, s.addr);
        check($sformatf("%s.c%0d.Hwrite", name, c), 32'(Hwrite), 32'(s.wr));
      end
      if (s.chk_wd)
        check($sformatf("%s.c%0d.Hwdata", name, c), Hwdata, s.wd);
      check($sformatf("%s.c%0d.done", name, c), 32'(done), 32'(s.done));
      check($sformatf("%s.c%0d.busy", name, c), 32'(busy), 32'(s.busy));
      @(negedge Hclk);
      start = 1'b0;
      // Command fields must be latched, so garbage after the strobe is harmless.
      if (s.start) begin
        cmd_addr  = $urandom;
        cmd_seed  = $urandom;
        cmd_write = 1'($urandom);
        cmd_len   = LEN_W'($urandom);
      end
      c++;
    end
  endtask

  task automatic set_cmd(input bit wr, input logic [31:0] addr,
                         input logic [LEN_W-1:0] len, input logic [31:0] seed);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_seed  = seed;
  endtask

  initial begin
    Hreset    = 1'b1;
    start     = 1'b0;
    Hreadyout = 1'b1;
    Hresp     = 2'b00;
    Hrdata    = '0;
    set_cmd(1'b0, 32'h0, '0, 32'h0);
    repeat (2) @(negedge Hclk);
    Hreset = 1'b0;

    check("rst.Htrans", 32'(Htrans), 32'h0);
    check("rst.Haddr", Haddr, 32'h0);
    check("rst.Hwdata", Hwdata, 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.mismatch", 32'(mismatch_cnt), 32'h0);
    check("rst.Hsize", 32'(Hsize), 32'h2);
    check("rst.Hreadyin", 32'(Hreadyin), 32'h1);

    // Single write, zero wait states.
    set_cmd(1'b1, 32'h100, 5'd1, 32'hA5);
    push_idle(1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, NS, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 32'hA5, 1'b0, 1'b1);
    push_done();
    run("single_wr");
    check("single_wr.err_resp", 32'(err_resp), 32'h0);

    // Four-beat write; a second start mid-burst must be ignored.
    set_cmd(1'b1, 32'h40, 5'd4, 32'h10);
    push_idle(1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, NS, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 1; k < 4; k++)
      push(k == 2, 1'b1, 2'b00, 32'h0, SQ, 32'h40 + 32'(4 * k), 1'b1, 1'b1,
           32'h10 + 32'(k - 1), 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 32'h13, 1'b0, 1'b1);
    push_done();
    push_idle(1'b0);
    run("burst_wr");

    // Four-beat read with one corrupted beat.
    set_cmd(1'b0, 32'h80, 5'd4, 32'h20);
    push_idle(1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0,    NS, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h20,   SQ, 32'h84, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h21,   SQ, 32'h88, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'hDEAD, SQ, 32'h8C, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h23, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    push_done();
    run("burst_rd");
    check("burst_rd.mismatch", 32'(mismatch_cnt), 32'h1);

    // ERROR response on the beat-1 data phase of a four-beat write.
    set_cmd(1'b1, 32'h300, 5'd4, 32'h70);
    push_idle(1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, NS, 32'h300, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, SQ, 32'h304, 1'b1, 1'b1, 32'h70, 1'b0, 1'b1);
    push(1'b0, 1'b0, 2'b01, 32'h0, SQ, 32'h308, 1'b1, 1'b1, 32'h71, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b01, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    push_done();
    push_idle(1'b0);
    run("err_wr");
    check("err_wr.err_resp", 32'(err_resp), 32'h1);

    // Two wait states in the beat-0 data phase; the new start clears err_resp.
    set_cmd(1'b1, 32'h200, 5'd2, 32'h55);
    push_idle(1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, NS, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 2'b00, 32'h0, SQ, 32'h204, 1'b1, 1'b1, 32'h55, 1'b0, 1'b1);
    push(1'b0, 1'b0, 2'b00, 32'h0, SQ, 32'h204, 1'b1, 1'b1, 32'h55, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, SQ, 32'h204, 1'b1, 1'b1, 32'h55, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 32'h56, 1'b0, 1'b1);
    push_done();
    run("wait_wr");
    check("wait_wr.err_resp", 32'(err_resp), 32'h0);

    // Zero-length command completes with no bus activity.
    set_cmd(1'b1, 32'h600, 5'd0, 32'h1);
    push_idle(1'b1);
    push_done();
    push_idle(1'b0);
    run("len0");

    // Asynchronous reset in the middle of a burst, between clock edges.
    set_cmd(1'b1, 32'h500, 5'd4, 32'h33);
    push_idle(1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, NS, 32'h500, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, SQ, 32'h504, 1'b1, 1'b1, 32'h33, 1'b0, 1'b1);
    run("pre_rst");
    #2 Hreset = 1'b1;
    #1;
    check("mid_rst.Htrans", 32'(Htrans), 32'h0);
    check("mid_rst.Haddr", Haddr, 32'h0);
    check("mid_rst.Hwrite", 32'(Hwrite), 32'h0);
    check("mid_rst.Hwdata", Hwdata, 32'h0);
    check("mid_rst.busy", 32'(busy), 32'h0);
    check("mid_rst.done", 32'(done), 32'h0);
    @(negedge Hclk);
    Hreset = 1'b0;

    // Address wrap across the top of the address space.
    set_cmd(1'b1, 32'hFFFF_FFFC, 5'd2, 32'h9);
    push_idle(1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, NS, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, SQ, 32'h0000_0000, 1'b1, 1'b1, 32'h9, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 32'hA, 1'b0, 1'b1);
    push_done();
    run("wrap_wr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
